// File: rtl/fpu_input_unpacker_pkg.sv
// Shared constants, types and helpers for the FPU input unpacker.
package fpu_input_unpacker_pkg;

    localparam int REG_SIZE  = 64;
    localparam int MANT_W    = 53;
    localparam int EXP_OUT_W = 13;

    // Single-precision field layout
    localparam int SP_FRAC_W  = 23;
    localparam int SP_EXP_LSB = 23;
    localparam int SP_EXP_W   = 8;
    localparam int SP_SIGN    = 31;
    localparam int SP_BIAS    = 127;

    // Double-precision field layout
    localparam int DP_FRAC_W  = 52;
    localparam int DP_EXP_LSB = 52;
    localparam int DP_EXP_W   = 11;
    localparam int DP_SIGN    = 63;
    localparam int DP_BIAS    = 1023;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // One unpacked operand; sub marks an operand that still owes normalization
    typedef struct packed {
        logic                 sign;
        logic [MANT_W-1:0]    mant;
        logic [EXP_OUT_W-1:0] expo;
        logic                 nan;
        logic                 inf;
        logic                 zero;
        logic                 err;
        logic                 sub;
    } op_t;

    // Hidden-bit position for the current format
    function automatic logic hidden_bit(input op_t op, input logic mode);
        return mode ? op.mant[DP_FRAC_W] : op.mant[SP_FRAC_W];
    endfunction

    // One normalization step: shift a subnormal left until the hidden bit is set
    function automatic op_t norm_step(input op_t op, input logic mode);
        op_t r;
        r = op;
        if (op.sub && !hidden_bit(op, mode)) begin
            r.mant = op.mant << 1;
            r.expo = op.expo - EXP_OUT_W'(1);
        end
        return r;
    endfunction

    function automatic logic is_norm(input op_t op, input logic mode);
        return !op.sub || hidden_bit(op, mode);
    endfunction

endpackage

// File: rtl/fpu_input_unpacker_if.sv
// Operand/result handshake bundle between the issuing side and the unpacker.
interface fpu_input_unpacker_if;
    import fpu_input_unpacker_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic                 mode;
    logic [REG_SIZE-1:0]  inA;
    logic [REG_SIZE-1:0]  inB;
    logic                 out_valid;
    logic                 out_ready;
    logic                 mode_out;
    logic                 signA, signB;
    logic [MANT_W-1:0]    mantA, mantB;
    logic [EXP_OUT_W-1:0] expA, expB;
    logic                 nanA, nanB, infA, infB, zeroA, zeroB, errA, errB;

    modport master (
        output in_valid, mode, inA, inB, out_ready,
        input  in_ready, out_valid, mode_out, signA, signB, mantA, mantB,
               expA, expB, nanA, nanB, infA, infB, zeroA, zeroB, errA, errB
    );

    modport slave (
        input  in_valid, mode, inA, inB, out_ready,
        output in_ready, out_valid, mode_out, signA, signB, mantA, mantB,
               expA, expB, nanA, nanB, infA, infB, zeroA, zeroB, errA, errB
    );

endinterface

// File: rtl/fpu_input_unpacker_decode.sv
// Combinational field split and classification of one packed operand.
module fpu_operand_decode
    import fpu_input_unpacker_pkg::*;
(
    input  logic                mode_i,
    input  logic [REG_SIZE-1:0] op_i,
    output op_t                 dec_o
);

    logic [DP_EXP_W-1:0]  e;
    logic [DP_FRAC_W-1:0] f;
    logic                 sign, e_ones, f_msb;
    logic [EXP_OUT_W-1:0] bias;
    logic [MANT_W-1:0]    hid;

    // Extract fields into double-width containers so classification is format-agnostic
    always_comb begin
        if (mode_i) begin
            e      = op_i[DP_EXP_LSB +: DP_EXP_W];
            f      = op_i[0 +: DP_FRAC_W];
            sign   = op_i[DP_SIGN];
            e_ones = &op_i[DP_EXP_LSB +: DP_EXP_W];
            f_msb  = op_i[DP_FRAC_W-1];
            bias   = EXP_OUT_W'(DP_BIAS);
            hid    = MANT_W'(1) << DP_FRAC_W;
        end else begin
            e      = DP_EXP_W'(op_i[SP_EXP_LSB +: SP_EXP_W]);
            f      = DP_FRAC_W'(op_i[0 +: SP_FRAC_W]);
            sign   = op_i[SP_SIGN];
            e_ones = &op_i[SP_EXP_LSB +: SP_EXP_W];
            f_msb  = op_i[SP_FRAC_W-1];
            bias   = EXP_OUT_W'(SP_BIAS);
            hid    = MANT_W'(1) << SP_FRAC_W;
        end
    end

    // Classify and form the initial mantissa/exponent
    always_comb begin
        dec_o      = '0;
        dec_o.sign = sign;
        if (e == '0) begin
            if (f == '0) begin
                dec_o.zero = 1'b1;
            end else begin
                dec_o.sub  = 1'b1;
                dec_o.mant = MANT_W'(f);
                dec_o.expo = EXP_OUT_W'(1) - bias;
            end
        end else if (e_ones) begin
            if (f == '0) begin
                dec_o.inf = 1'b1;
            end else begin
                dec_o.nan  = 1'b1;
                dec_o.err  = !f_msb;
                dec_o.mant = MANT_W'(f);
            end
        end else begin
            dec_o.mant = MANT_W'(f) | hid;
            dec_o.expo = EXP_OUT_W'(e) - bias;
        end
    end

endmodule

// File: rtl/fpu_input_unpacker.sv
// FPU front-end: captures an operand pair, normalizes subnormals one bit per
// cycle and holds the unpacked result until the core accepts it.
module fpu_input_unpacker
    import fpu_input_unpacker_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_input_unpacker_if.slave  bus
);

    state_e state_q, state_d;
    logic   mode_q, mode_d;
    op_t    opa_q, opa_d, opb_q, opb_d;
    op_t    dec_a, dec_b;

    fpu_operand_decode u_dec_a (.mode_i(bus.mode), .op_i(bus.inA), .dec_o(dec_a));
    fpu_operand_decode u_dec_b (.mode_i(bus.mode), .op_i(bus.inB), .dec_o(dec_b));

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    // Next state: capture in IDLE, shift both operands in NORM, wait in HOLD
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    mode_d  = bus.mode;
                    opa_d   = dec_a;
                    opb_d   = dec_b;
                    state_d = (dec_a.sub || dec_b.sub) ? ST_NORM : ST_HOLD;
                end
            end
            ST_NORM: begin
                opa_d = norm_step(opa_q, mode_q);
                opb_d = norm_step(opb_q, mode_q);
                // Leave as soon as the shift lands the last hidden bit
                if (is_norm(opa_d, mode_q) && is_norm(opb_d, mode_q))
                    state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs; in_ready is forced low while reset is held
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE) && rst_n;
        bus.out_valid = (state_q == ST_HOLD);
    end

    assign bus.mode_out = mode_q;
    assign bus.signA    = opa_q.sign;
    assign bus.mantA    = opa_q.mant;
    assign bus.expA     = opa_q.expo;
    assign bus.nanA     = opa_q.nan;
    assign bus.infA     = opa_q.inf;
    assign bus.zeroA    = opa_q.zero;
    assign bus.errA     = opa_q.err;
    assign bus.signB    = opb_q.sign;
    assign bus.mantB    = opb_q.mant;
    assign bus.expB     = opb_q.expo;
    assign bus.nanB     = opb_q.nan;
    assign bus.infB     = opb_q.inf;
    assign bus.zeroB    = opb_q.zero;
    assign bus.errB     = opb_q.err;

endmodule

// File: tb/tb_fpu_input_unpacker.sv
// Scoreboard bench for fpu_input_unpacker: directed operand pairs with
// hand-derived expected results, back-pressure and mid-operation reset.
module tb_fpu_input_unpacker;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    fpu_input_unpacker_if bus();

    fpu_input_unpacker dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [63:0] a, b;
        logic        sa, sb;
        logic [52:0] ma, mb;
        logic [12:0] ea, eb;
        logic [3:0]  fa, fb;   // {nan, inf, zero, err}
        int          lat;
    } vec_t;

    vec_t sb_q[$];
    vec_t vecs[8];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic vec_t mk(input logic m, input logic [63:0] a, input logic [63:0] b,
                                input logic sa, input logic [52:0] ma, input logic [12:0] ea, input logic [3:0] fa,
                                input logic sb, input logic [52:0] mb, input logic [12:0] eb, input logic [3:0] fb,
                                input int lat);
        vec_t v;
        v.mode = m; v.a = a; v.b = b;
        v.sa = sa; v.ma = ma; v.ea = ea; v.fa = fa;
        v.sb = sb; v.mb = mb; v.eb = eb; v.fb = fb;
        v.lat = lat;
        return v;
    endfunction

    // Present one pair, wait for the result and check it against the scoreboard
    task automatic run(input vec_t v, input int hold);
        vec_t e;
        int   lat;
        logic [52:0] ma_hold;
        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.mode = v.mode; bus.inA = v.a; bus.inB = v.b; bus.in_valid = 1'b1;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid", 64'(bus.out_valid), 64'd1);
        e = sb_q.pop_front();
        chk("latency", 64'(lat), 64'(e.lat));
        chk("mode_out", 64'(bus.mode_out), 64'(e.mode));
        chk("signA", 64'(bus.signA), 64'(e.sa));
        chk("mantA", 64'(bus.mantA), 64'(e.ma));
        chk("expA", 64'(bus.expA), 64'(e.ea));
        chk("flagsA", 64'({bus.nanA, bus.infA, bus.zeroA, bus.errA}), 64'(e.fa));
        chk("signB", 64'(bus.signB), 64'(e.sb));
        chk("mantB", 64'(bus.mantB), 64'(e.mb));
        chk("expB", 64'(bus.expB), 64'(e.eb));
        chk("flagsB", 64'({bus.nanB, bus.infB, bus.zeroB, bus.errB}), 64'(e.fb));
        ma_hold = bus.mantA;
        // Back-pressure: inputs wiggle, result must not move
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = ~bus.in_valid;
            bus.inA = {$urandom, $urandom};
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_mantA", 64'(bus.mantA), 64'(ma_hold));
            chk("hold_expA", 64'(bus.expA), 64'(e.ea));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("release_valid", 64'(bus.out_valid), 64'd0);
        chk("release_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.mode = 1'b0;
        bus.inA = '0; bus.inB = '0;
        rst_n = 1'b0;

        vecs[0] = mk(1'b0, 64'h3F800000, 64'hC0000000,
                     1'b0, 53'h800000, 13'd0, 4'b0000, 1'b1, 53'h800000, 13'd1, 4'b0000, 1);
        vecs[1] = mk(1'b0, 64'h00000001, 64'h3F800000,
                     1'b0, 53'h800000, -13'sd149, 4'b0000, 1'b0, 53'h800000, 13'd0, 4'b0000, 24);
        vecs[2] = mk(1'b1, 64'h0000000000000001, 64'h0008000000000000,
                     1'b0, 53'h10000000000000, -13'sd1074, 4'b0000, 1'b0, 53'h10000000000000, -13'sd1023, 4'b0000, 53);
        vecs[3] = mk(1'b0, 64'h7F800000, 64'h7F800001,
                     1'b0, 53'h0, 13'd0, 4'b0100, 1'b0, 53'h1, 13'd0, 4'b1001, 1);
        vecs[4] = mk(1'b0, 64'h7F800000, 64'h7FC00000,
                     1'b0, 53'h0, 13'd0, 4'b0100, 1'b0, 53'h400000, 13'd0, 4'b1000, 1);
        vecs[5] = mk(1'b0, 64'hDEADBEEF80000000, 64'hFFFFFFFF00400000,
                     1'b1, 53'h0, 13'd0, 4'b0010, 1'b0, 53'h800000, -13'sd127, 4'b0000, 2);
        vecs[6] = mk(1'b1, 64'h3FF0000000000000, 64'hFFF0000000000000,
                     1'b0, 53'h10000000000000, 13'd0, 4'b0000, 1'b1, 53'h0, 13'd0, 4'b0100, 1);
        vecs[7] = mk(1'b1, 64'h7FF0000000000001, 64'h800FFFFFFFFFFFFF,
                     1'b0, 53'h1, 13'd0, 4'b1001, 1'b1, 53'h1FFFFFFFFFFFFE, -13'sd1023, 4'b0000, 2);

        // Reset state
        #12;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mantA", 64'(bus.mantA), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run(vecs[i], 0);

        // Back-pressure with toggling inputs
        run(vecs[0], 5);

        // Reset in the middle of a long normalization
        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.mode = 1'b1; bus.inA = vecs[2].a; bus.inB = vecs[2].b; bus.in_valid = 1'b1;
        sb_q.push_back(vecs[2]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("midrst_mant", 64'({bus.mantA, bus.mantB} != '0), 64'd0);
        chk("midrst_exp", 64'({bus.expA, bus.expB}), 64'd0);
        chk("midrst_misc", 64'({bus.mode_out, bus.signA, bus.signB, bus.nanA, bus.nanB, bus.infA,
                                bus.infB, bus.zeroA, bus.zeroB, bus.errA, bus.errB}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(vecs[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
